// File: rtl/cpu_pkg.sv
// Shared definitions for the 16-bit pipelined core: word types, the
// fetch/decode packet, instruction field positions and special opcodes.
package cpu_pkg;

  typedef logic [15:0] addr;
  typedef logic [15:0] block;

  // Packet handed from fetch to decode.
  typedef struct packed {
    addr      pc;
    bit [15:0] inst;
  } inst;

  // Instruction field positions (msb/lsb).
  localparam int op_begin = 15;
  localparam int op_end   = 12;
  localparam int rd_begin = 11;
  localparam int rd_end   = 9;
  localparam int rs_begin = 8;
  localparam int rs_end   = 6;
  localparam int rt_begin = 5;
  localparam int rt_end   = 3;
  localparam int i9_begin = 8;
  localparam int i9_end   = 0;

  localparam logic [3:0] OP_HALT = 4'b1111;
  localparam logic [3:0] OP_NOP  = 4'b0000;

  // Fetch control state.
  typedef enum logic {
    FS_RUN    = 1'b0,
    FS_HALTED = 1'b1
  } fetch_state_e;

endpackage

// File: rtl/fetch_unit.sv
// Instruction fetch stage: owns the PC, drives a synchronous-read
// instruction memory and presents {pc, inst} packets to decode.
//
// Handshake: a packet is offered whenever fetch_valid=1 and is taken by
// decode in any cycle where stall=0. While stall=1 the offered packet is
// frozen in the hold register and re-offered until the first stall=0 cycle.
// A redirect (do_branch/do_jump) discards whatever is offered that cycle.
module fetch_unit
  import cpu_pkg::*;
#(
  parameter addr        RESET_PC = 16'h0000,
  parameter logic [3:0] OP_HALT  = cpu_pkg::OP_HALT
) (
  input  logic clk,
  input  logic rst,
  output logic imem_en,
  output addr  imem_addr,
  input  block imem_rdata,
  input  logic stall,
  input  logic do_branch,
  input  addr  branch_target,
  input  logic do_jump,
  input  addr  jump_address,
  output inst  fetch_inst,
  output logic fetch_valid,
  output logic halted
);

  addr          pc_q, pc_d;
  logic         resp_valid_q, resp_valid_d;
  addr          resp_pc_q, resp_pc_d;
  logic         hold_valid_q, hold_valid_d;
  inst          hold_word_q, hold_word_d;
  fetch_state_e fsm_q, fsm_d;

  logic redirect;
  addr  target;
  inst  out_word;
  logic out_is_halt;
  logic issue;

  // Output select, issue decision and next-state computation.
  always_comb begin
    // Redirects are ignored while reset is asserted so the memory port
    // stays quiet at RESET_PC.
    redirect = rst & (do_branch | do_jump);
    target   = do_branch ? branch_target : jump_address;

    out_word = '0;
    if (hold_valid_q) begin
      out_word = hold_word_q;
    end else if (resp_valid_q) begin
      out_word.pc   = resp_pc_q;
      out_word.inst = imem_rdata;
    end

    fetch_valid = hold_valid_q | resp_valid_q;
    out_is_halt = fetch_valid && (out_word.inst[op_begin:op_end] == OP_HALT);

    // Redirect always issues; otherwise only when running, accepted, and
    // not looking at a HALT (nothing after a HALT is fetched).
    issue     = redirect | ((fsm_q == FS_RUN) & ~stall & ~out_is_halt);
    imem_en   = issue & rst;
    imem_addr = redirect ? target : pc_q;

    fetch_inst = out_word;
    halted     = (fsm_q == FS_HALTED);

    pc_d = pc_q;
    if (redirect) begin
      pc_d = target + 16'd1;
    end else if (issue) begin
      pc_d = pc_q + 16'd1;
    end

    resp_valid_d = issue;
    resp_pc_d    = imem_addr;

    hold_valid_d = 1'b0;
    hold_word_d  = hold_word_q;
    if (!redirect && stall && fetch_valid) begin
      hold_valid_d = 1'b1;
      hold_word_d  = out_word;
    end

    fsm_d = fsm_q;
    if (redirect) begin
      fsm_d = FS_RUN;
    end else if (out_is_halt && !stall) begin
      fsm_d = FS_HALTED;
    end
  end

  // State registers, cleared asynchronously by the active-low reset.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      pc_q         <= RESET_PC;
      resp_valid_q <= 1'b0;
      resp_pc_q    <= RESET_PC;
      hold_valid_q <= 1'b0;
      hold_word_q  <= '0;
      fsm_q        <= FS_RUN;
    end else begin
      pc_q         <= pc_d;
      resp_valid_q <= resp_valid_d;
      resp_pc_q    <= resp_pc_d;
      hold_valid_q <= hold_valid_d;
      hold_word_q  <= hold_word_d;
      fsm_q        <= fsm_d;
    end
  end

endmodule
